// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - ID-stage bus: IF/ID + control + WB inputs, ID/EX pipeline outputs
//
// Purpose: bundles every non-clock/reset signal of decode_stage.
//   master : decode-stage side (consumes ID/WB inputs, drives stall and ID/EX fields)
//   slave  : surrounding pipeline side (drives ID/WB inputs, consumes stall and ID/EX fields)
// Signals:
//   instr_ID[31:0], pc_ID[WIDTH-1:0], ctrl_ID[11:0], signExt_ID  - instruction in ID
//   flush                                                        - squash the ID instruction
//   wbEn, wbAddr[4:0], wbData[WIDTH-1:0]                         - register write-back
//   stall_ID                                                     - hold PC and IF/ID
//   readData1_EX, readData2_EX, extImm_EX, shamt_EX, rd_EX,
//   ctrl_EX, forwardA_EX, forwardB_EX, pc_EX                     - ID/EX register
interface decode_stage_if #(
  parameter int WIDTH = 32
);
  logic [31:0]      instr_ID;
  logic [WIDTH-1:0] pc_ID;
  logic [11:0]      ctrl_ID;
  logic             signExt_ID;
  logic             flush;
  logic             wbEn;
  logic [4:0]       wbAddr;
  logic [WIDTH-1:0] wbData;

  logic             stall_ID;
  logic [WIDTH-1:0] readData1_EX;
  logic [WIDTH-1:0] readData2_EX;
  logic [WIDTH-1:0] extImm_EX;
  logic [4:0]       shamt_EX;
  logic [4:0]       rd_EX;
  logic [11:0]      ctrl_EX;
  logic [1:0]       forwardA_EX;
  logic [1:0]       forwardB_EX;
  logic [WIDTH-1:0] pc_EX;

  modport master (
    input  instr_ID, pc_ID, ctrl_ID, signExt_ID, flush, wbEn, wbAddr, wbData,
    output stall_ID, readData1_EX, readData2_EX, extImm_EX, shamt_EX, rd_EX,
           ctrl_EX, forwardA_EX, forwardB_EX, pc_EX
  );

  modport slave (
    output instr_ID, pc_ID, ctrl_ID, signExt_ID, flush, wbEn, wbAddr, wbData,
    input  stall_ID, readData1_EX, readData2_EX, extImm_EX, shamt_EX, rd_EX,
           ctrl_EX, forwardA_EX, forwardB_EX, pc_EX
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS ID stage: register file, immediate extend, forwarding, load-use hazard
//
// Purpose: decodes the IF/ID instruction, reads the 32x32 register file (write-first
// bypass from WB), extends the immediate, computes registered forwarding selects and
// detects load-use hazards, and drives the ID/EX pipeline register.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - decode_stage_if.master (see interface for the signal list)
// ctrl bundle layout: {RegWrite,MemtoReg,MemRead,MemWrite,RegDst,ALUSrc,Branch,bne,ALUOp[3:0]}
module decode_stage #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.master bus
);

  localparam int C_REGWRITE = 11;
  localparam int C_MEMREAD  = 9;
  localparam int C_REGDST   = 7;

  // Field decode
  logic [4:0]  rs, rt, rd_sel;
  logic [15:0] imm;
  logic [WIDTH-1:0] ext_imm;
  logic        unused_opcode;

  assign rs     = bus.instr_ID[25:21];
  assign rt     = bus.instr_ID[20:16];
  assign imm    = bus.instr_ID[15:0];
  assign rd_sel = bus.ctrl_ID[C_REGDST] ? bus.instr_ID[15:11] : bus.instr_ID[20:16];
  assign ext_imm = bus.signExt_ID ? {{(WIDTH-16){imm[15]}}, imm} : {{(WIDTH-16){1'b0}}, imm};
  assign unused_opcode = ^bus.instr_ID[31:26];

  // Register file: two async read ports, one sync write port
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] rd1, rd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (bus.wbEn && bus.wbAddr != 5'd0) begin
      regs_q[bus.wbAddr] <= bus.wbData;
    end
  end

  // Write-first: a register being written back this cycle is seen by ID now,
  // so WB->ID needs no forwarding select of its own.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs != 5'd0) rd1 = (bus.wbEn && bus.wbAddr == rs) ? bus.wbData : regs_q[rs];
    if (rt != 5'd0) rd2 = (bus.wbEn && bus.wbAddr == rt) ? bus.wbData : regs_q[rt];
  end

  // ID/EX state and MEM-stage tracking
  logic [WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d, ext_imm_q, ext_imm_d, pc_q, pc_d;
  logic [4:0]       shamt_q, shamt_d, rd_q, rd_d;
  logic [11:0]      ctrl_q, ctrl_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic             mem_reg_write_q;
  logic [4:0]       mem_rd_q;
  logic             haz;

  // The instruction now in EX will be in MEM when ID's instruction reaches EX (10);
  // the one now in MEM will be in WB (01). The EX producer is newer, so it wins.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic ex_rw, input logic [4:0] ex_rd,
                                         input logic mem_rw, input logic [4:0] mem_rd);
    if (ex_rw && ex_rd != 5'd0 && ex_rd == src)         return 2'b10;
    else if (mem_rw && mem_rd != 5'd0 && mem_rd == src) return 2'b01;
    else                                                return 2'b00;
  endfunction

  assign haz = ctrl_q[C_MEMREAD] && rd_q != 5'd0 && (rd_q == rs || rd_q == rt);
  // A flush redirects fetch anyway, so never hold IF/ID against it.
  assign bus.stall_ID = haz && !bus.flush;

  always_comb begin
    rd1_d     = '0;
    rd2_d     = '0;
    ext_imm_d = '0;
    pc_d      = '0;
    shamt_d   = '0;
    rd_d      = '0;
    ctrl_d    = '0;
    fwd_a_d   = 2'b00;
    fwd_b_d   = 2'b00;
    if (!(bus.flush || haz)) begin
      rd1_d     = rd1;
      rd2_d     = rd2;
      ext_imm_d = ext_imm;
      pc_d      = bus.pc_ID;
      shamt_d   = bus.instr_ID[10:6];
      rd_d      = rd_sel;
      ctrl_d    = bus.ctrl_ID;
      fwd_a_d   = fwd_sel(rs, ctrl_q[C_REGWRITE], rd_q, mem_reg_write_q, mem_rd_q);
      fwd_b_d   = fwd_sel(rt, ctrl_q[C_REGWRITE], rd_q, mem_reg_write_q, mem_rd_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_q           <= '0;
      rd2_q           <= '0;
      ext_imm_q       <= '0;
      pc_q            <= '0;
      shamt_q         <= '0;
      rd_q            <= '0;
      ctrl_q          <= '0;
      fwd_a_q         <= 2'b00;
      fwd_b_q         <= 2'b00;
      mem_reg_write_q <= 1'b0;
      mem_rd_q        <= '0;
    end else begin
      rd1_q           <= rd1_d;
      rd2_q           <= rd2_d;
      ext_imm_q       <= ext_imm_d;
      pc_q            <= pc_d;
      shamt_q         <= shamt_d;
      rd_q            <= rd_d;
      ctrl_q          <= ctrl_d;
      fwd_a_q         <= fwd_a_d;
      fwd_b_q         <= fwd_b_d;
      mem_reg_write_q <= ctrl_q[C_REGWRITE];
      mem_rd_q        <= rd_q;
    end
  end

  assign bus.readData1_EX = rd1_q;
  assign bus.readData2_EX = rd2_q;
  assign bus.extImm_EX    = ext_imm_q;
  assign bus.shamt_EX     = shamt_q;
  assign bus.rd_EX        = rd_q;
  assign bus.ctrl_EX      = ctrl_q;
  assign bus.forwardA_EX  = fwd_a_q;
  assign bus.forwardB_EX  = fwd_b_q;
  assign bus.pc_EX        = pc_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if #(.WIDTH(32)) bus();
  decode_stage #(.WIDTH(32), .NREG(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [11:0] C_ADD = 12'h882;  // RegWrite, RegDst, ALUOp=0010
  localparam logic [11:0] C_LW  = 12'hE40;  // RegWrite, MemtoReg, MemRead, ALUSrc

  typedef struct {
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  shamt, rd;
    logic [11:0] ctrl;
    logic [1:0]  fa, fb;
  } idex_t;

  typedef struct {
    logic [31:0] instr;
    logic [11:0] ctrl;
    logic        sx;
    logic [31:0] pc;
    logic [31:0] exp_imm;
    logic [4:0]  exp_rd;
    logic [4:0]  exp_shamt;
  } vec_t;

  typedef struct {
    logic       rw;
    logic [4:0] rd;
  } wr_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idex(input string tag, input idex_t e);
    chk($sformatf("%s.readData1", tag), bus.readData1_EX, e.rd1);
    chk($sformatf("%s.readData2", tag), bus.readData2_EX, e.rd2);
    chk($sformatf("%s.extImm", tag), bus.extImm_EX, e.imm);
    chk($sformatf("%s.shamt", tag), 32'(bus.shamt_EX), 32'(e.shamt));
    chk($sformatf("%s.rd", tag), 32'(bus.rd_EX), 32'(e.rd));
    chk($sformatf("%s.ctrl", tag), 32'(bus.ctrl_EX), 32'(e.ctrl));
    chk($sformatf("%s.fwdA", tag), 32'(bus.forwardA_EX), 32'(e.fa));
    chk($sformatf("%s.fwdB", tag), 32'(bus.forwardB_EX), 32'(e.fb));
    chk($sformatf("%s.pc", tag), bus.pc_EX, e.pc);
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh);
    return {6'd0, rs, rt, rd, sh, 6'h20};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [11:0] ctrl, input logic sx,
                       input logic [31:0] pc, input logic fl, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    bus.instr_ID   = instr;
    bus.ctrl_ID    = ctrl;
    bus.signExt_ID = sx;
    bus.pc_ID      = pc;
    bus.flush      = fl;
    bus.wbEn       = we;
    bus.wbAddr     = wa;
    bus.wbData     = wd;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] instr, input logic [11:0] ctrl);
    drive(instr, ctrl, 1'b1, 32'h40, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
  endtask

  // Reset held two cycles under random inputs; everything must read zero.
  task automatic do_reset(input string tag);
    idex_t z;
    z = '{default: '0};
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive($urandom, 12'($urandom), 1'($urandom), $urandom, 1'($urandom),
            1'($urandom), 5'($urandom), $urandom);
      tick();
    end
    #1;
    chk_idex(tag, z);
    chk($sformatf("%s.stall", tag), 32'(bus.stall_ID), 32'd0);
    rst = 1'b0;
  endtask

  // Behavioural model state for the random phase
  logic [31:0] m_regs [32];
  idex_t       m_ex;
  wr_t         hist[$];  // hist[0]: instruction in EX, hist[1]: instruction in MEM

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (bus.wbEn && bus.wbAddr == r) return bus.wbData;
    return m_regs[r];
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    for (int d = 0; d < 2; d++)
      if (hist[d].rw && hist[d].rd != 5'd0 && hist[d].rd == src)
        return (d == 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  vec_t vecs[6];

  initial begin
    idex_t nxt;
    logic [4:0] rs, rt;
    logic mhaz;

    vecs[0] = '{i_type(6'h08, 5'd5, 5'd9, 16'h8000), 12'h840, 1'b1, 32'h100,
                32'hFFFF8000, 5'd9, 5'd0};
    vecs[1] = '{i_type(6'h08, 5'd5, 5'd9, 16'h8000), 12'h840, 1'b0, 32'h104,
                32'h00008000, 5'd9, 5'd0};
    vecs[2] = '{r_type(5'd1, 5'd2, 5'd3, 5'd5), C_ADD, 1'b1, 32'h108,
                32'h00001960, 5'd3, 5'd5};
    vecs[3] = '{i_type(6'h04, 5'd31, 5'd30, 16'hFFFF), 12'h021, 1'b1, 32'hFFFFFFFC,
                32'hFFFFFFFF, 5'd30, 5'd31};
    vecs[4] = '{i_type(6'h05, 5'd17, 5'd18, 16'h7FFF), 12'h031, 1'b1, 32'h2000,
                32'h00007FFF, 5'd18, 5'd31};
    vecs[5] = '{r_type(5'd12, 5'd13, 5'd0, 5'd0), C_ADD, 1'b0, 32'h10,
                32'h00000020, 5'd0, 5'd0};

    drive(32'd0, 12'd0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    do_reset("reset");

    // Table vectors: fresh register file reads zero everywhere
    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].ctrl, vecs[i].sx, vecs[i].pc, 1'b0, 1'b0, 5'd0, 32'd0);
      tick();
      chk($sformatf("vec%0d.extImm", i), bus.extImm_EX, vecs[i].exp_imm);
      chk($sformatf("vec%0d.rd", i), 32'(bus.rd_EX), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d.shamt", i), 32'(bus.shamt_EX), 32'(vecs[i].exp_shamt));
      chk($sformatf("vec%0d.ctrl", i), 32'(bus.ctrl_EX), 32'(vecs[i].ctrl));
      chk($sformatf("vec%0d.pc", i), bus.pc_EX, vecs[i].pc);
      chk($sformatf("vec%0d.rd1", i), bus.readData1_EX, 32'd0);
      chk($sformatf("vec%0d.rd2", i), bus.readData2_EX, 32'd0);
    end

    // Bypass and $0
    do_reset("reset2");
    drive(r_type(5'd5, 5'd0, 5'd1, 5'd0), 12'd0, 1'b1, 32'h0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    chk("bypass.rd1", bus.readData1_EX, 32'hDEADBEEF);
    drive(r_type(5'd0, 5'd5, 5'd1, 5'd0), 12'd0, 1'b1, 32'h0, 1'b0, 1'b1, 5'd0, 32'hCAFEF00D);
    tick();
    chk("reg0.rd1", bus.readData1_EX, 32'd0);
    chk("stored.rd2", bus.readData2_EX, 32'hDEADBEEF);

    // Reset mid-operation overrides flush and write-back
    rst = 1'b1;
    drive(r_type(5'd1, 5'd2, 5'd3, 5'd0), C_ADD, 1'b1, 32'h44, 1'b1, 1'b1, 5'd9, 32'h55);
    tick();
    rst = 1'b0;
    chk("midrst.ctrl", 32'(bus.ctrl_EX), 32'd0);
    drive(r_type(5'd9, 5'd5, 5'd1, 5'd0), 12'd0, 1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    chk("midrst.reg9", bus.readData1_EX, 32'd0);
    chk("midrst.reg5", bus.readData2_EX, 32'd0);

    // Forwarding: back-to-back, one gap, rd=0 producer, priority
    do_reset("reset3");
    issue(r_type(5'd1, 5'd2, 5'd3, 5'd0), C_ADD);
    issue(r_type(5'd3, 5'd3, 5'd4, 5'd0), C_ADD);
    chk("fwd10.A", 32'(bus.forwardA_EX), 32'd2);
    chk("fwd10.B", 32'(bus.forwardB_EX), 32'd2);
    issue(r_type(5'd1, 5'd2, 5'd3, 5'd0), C_ADD);
    issue(r_type(5'd1, 5'd2, 5'd6, 5'd0), C_ADD);
    issue(r_type(5'd3, 5'd3, 5'd4, 5'd0), C_ADD);
    chk("fwd01.A", 32'(bus.forwardA_EX), 32'd1);
    chk("fwd01.B", 32'(bus.forwardB_EX), 32'd1);
    issue(r_type(5'd1, 5'd2, 5'd0, 5'd0), C_ADD);
    issue(r_type(5'd0, 5'd0, 5'd4, 5'd0), C_ADD);
    chk("fwdrd0.A", 32'(bus.forwardA_EX), 32'd0);
    chk("fwdrd0.B", 32'(bus.forwardB_EX), 32'd0);
    issue(r_type(5'd1, 5'd2, 5'd3, 5'd0), C_ADD);
    issue(r_type(5'd4, 5'd5, 5'd3, 5'd0), C_ADD);
    issue(r_type(5'd3, 5'd0, 5'd5, 5'd0), C_ADD);
    chk("prio.A", 32'(bus.forwardA_EX), 32'd2);
    chk("prio.B", 32'(bus.forwardB_EX), 32'd0);

    // Load-use: one-cycle stall, bubble, then forward from WB
    issue(i_type(6'h23, 5'd1, 5'd7, 16'd0), C_LW);
    drive(r_type(5'd7, 5'd2, 5'd8, 5'd0), C_ADD, 1'b1, 32'h80, 1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("lu.stall1", 32'(bus.stall_ID), 32'd1);
    tick();
    chk("lu.bubble.ctrl", 32'(bus.ctrl_EX), 32'd0);
    chk("lu.bubble.rd", 32'(bus.rd_EX), 32'd0);
    #1;
    chk("lu.stall2", 32'(bus.stall_ID), 32'd0);
    tick();
    chk("lu.retry.ctrl", 32'(bus.ctrl_EX), 32'(C_ADD));
    chk("lu.retry.A", 32'(bus.forwardA_EX), 32'd1);
    chk("lu.retry.B", 32'(bus.forwardB_EX), 32'd0);

    // Flush together with a load-use hazard
    issue(i_type(6'h23, 5'd1, 5'd7, 16'd0), C_LW);
    drive(r_type(5'd2, 5'd7, 5'd8, 5'd0), C_ADD, 1'b1, 32'h90, 1'b1, 1'b0, 5'd0, 32'd0);
    #1;
    chk("flhaz.stall", 32'(bus.stall_ID), 32'd0);
    tick();
    chk("flhaz.ctrl", 32'(bus.ctrl_EX), 32'd0);

    // Random phase against the behavioural model
    do_reset("reset4");
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_ex = '{default: '0};
    hist.delete();
    hist.push_back('{1'b0, 5'd0});
    hist.push_back('{1'b0, 5'd0});
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic [31:0] instr;
      instr = $urandom;
      instr[25:21] = 5'($urandom_range(0, 7));
      instr[20:16] = 5'($urandom_range(0, 7));
      instr[15:11] = 5'($urandom_range(0, 7));
      drive(instr, 12'($urandom), 1'($urandom), $urandom, ($urandom_range(0, 7) == 0),
            1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      #1;
      rs = instr[25:21];
      rt = instr[20:16];
      mhaz = m_ex.ctrl[9] && m_ex.rd != 5'd0 && (m_ex.rd == rs || m_ex.rd == rt);
      chk($sformatf("rnd%0d.stall", cyc), 32'(bus.stall_ID), 32'(mhaz && !bus.flush));
      nxt = '{default: '0};
      if (!(bus.flush || mhaz)) begin
        nxt.rd1   = m_read(rs);
        nxt.rd2   = m_read(rt);
        nxt.imm   = bus.signExt_ID ? 32'($signed(instr[15:0])) : 32'(instr[15:0]);
        nxt.pc    = bus.pc_ID;
        nxt.shamt = instr[10:6];
        nxt.rd    = bus.ctrl_ID[7] ? instr[15:11] : instr[20:16];
        nxt.ctrl  = bus.ctrl_ID;
        nxt.fa    = m_fwd(rs);
        nxt.fb    = m_fwd(rt);
      end
      if (bus.wbEn && bus.wbAddr != 5'd0) m_regs[bus.wbAddr] = bus.wbData;
      m_ex = nxt;
      hist.push_front('{nxt.ctrl[11], nxt.rd});
      void'(hist.pop_back());
      tick();
      chk_idex($sformatf("rnd%0d", cyc), m_ex);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 5-stage MIPS pipeline, directly upstream of the execute stage.
- Holds the 32x32 register file and extends the immediate.
- Generates registered forwarding selects and detects load-use hazards.
- Drives the ID/EX pipeline register that feeds execute: readData1/2, extImm, shamt, ALUOp, ALUSrc, Branch, bne, forwardA/B.

Parameters:
- WIDTH, 32, datapath/register width
- NREG, 32, register count (index width 5)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- instr_ID  in  32  instruction from IF/ID
- pc_ID  in  32  PC+4 of instr_ID
- ctrl_ID  in  12  from control unit: {RegWrite,MemtoReg,MemRead,MemWrite,RegDst,ALUSrc,Branch,bne,ALUOp[3:0]}
- signExt_ID  in  1  1=sign-extend imm, 0=zero-extend
- flush  in  1  branch taken/mispredict in EX; squash ID instruction
- wbEn  in  1  WB write enable
- wbAddr  in  5  WB destination
- wbData  in  32  WB data (same value execute sees as aluRes_WB)
- stall_ID  out  1  hold PC and IF/ID this cycle (combinational)
- readData1_EX, readData2_EX  out  32  registered operands
- extImm_EX  out  32  registered extended immediate
- shamt_EX  out  5  registered instr[10:6]
- rd_EX  out  5  registered destination (RegDst ? instr[15:11] : instr[20:16])
- ctrl_EX  out  12  registered control bundle
- forwardA_EX, forwardB_EX  out  2  registered select: 00 regfile, 01 WB, 10 MEM
- pc_EX  out  32  registered PC+4

Behaviour:
- Field decode: rs=instr[25:21], rt=instr[20:16], imm=instr[15:0].
- extImm = signExt ? {{16{imm[15]}},imm} : {16'b0,imm}.
- Register file:
  - 2 async read ports, 1 sync write port on posedge when wbEn && wbAddr!=0.
  - Reg 0 always reads 0.
  - Write-first bypass: if wbEn && wbAddr==rs (rs!=0), read returns wbData the same cycle; same for rt.
- Internal MEM tracking: register memRegWrite/memRd, loaded each cycle from ctrl_EX.RegWrite and rd_EX (the instruction moving EX->MEM).
- Forward select, computed in ID and registered into ID/EX; per source (rs for A, rt for B):
  - 10 if ctrl_EX.RegWrite && rd_EX!=0 && rd_EX==src (producer will be in MEM when consumer is in EX).
  - else 01 if memRegWrite && memRd!=0 && memRd==src (producer will be in WB).
  - else 00.
  - Priority: the 10 case wins over the 01 case (newest value).
- Load-use hazard: haz = ctrl_EX.MemRead && rd_EX!=0 && (rd_EX==rs || rd_EX==rt).
  - stall_ID = haz && !flush.
- ID/EX update on every posedge:
  - rst: all outputs 0 (ctrl_EX=0 is a NOP; forward selects 00; pc_EX=0). Register file contents 0. memRegWrite=0, memRd=0.
  - flush or haz: insert bubble. ctrl_EX=0, rd_EX=0, forward selects 00; data fields don't-care (drive 0).
  - otherwise: load all fields from ID.
- Simultaneous flush and haz: bubble inserted; stall_ID=0 so fetch takes the redirect.
- After a one-cycle load-use bubble the load is in WB. The retried consumer gets forward 01, or a regfile bypass if the load is already writing.
- Reset mid-operation: synchronous reset overrides flush, stall and WB write in that cycle.
- Latency: one cycle ID->EX. stall_ID and the register-file bypass are combinational.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> all outputs 0, stall_ID=0; read of any register returns 0.
- Bypass/$0: wbEn=1, wbAddr=5, wbData=0xDEADBEEF, instr rs=5 -> next cycle readData1_EX=0xDEADBEEF. wbAddr=0 write -> reg0 still reads 0.
- Forwarding:
  - add $3,$1,$2 ; add $4,$3,$3 -> second gets forwardA_EX=forwardB_EX=10.
  - One independent instruction between them -> 01.
  - Producer rd=0 -> 00.
- Priority: add $3 ; add $3 ; sub $5,$3,$0 -> forwardA=10 (newest producer).
- Load-use: lw $7,0($1) ; add $8,$7,$2 -> stall_ID=1 for exactly one cycle, ctrl_EX=0 bubble. add re-enters EX with forwardA=01.
- Flush with hazard: lw $7 in EX, ID uses $7, flush=1 -> stall_ID=0, ctrl_EX=0 next cycle. Immediate: imm=0x8000, signExt=1 -> extImm_EX=0xFFFF8000; signExt=0 -> 0x00008000.
